// File: rtl/cache_dre_ctrl_if.sv
// DRE maintenance bundle: flush/invalidate handshakes, status and the RAM maintenance port.
// Pure wiring; adds no latency.
// Requests are level-held by the requester until the matching one-cycle ack.
interface cache_dre_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  flush_req;
    logic [3:0]            flush_chMask;
    logic                  flush_ack;
    logic                  inv_req;
    logic [ADDR_WIDTH-1:0] inv_address;
    logic [1:0]            inv_channel;
    logic [3:0]            inv_byteMask;
    logic                  inv_ack;
    logic                  ready;
    logic                  busy;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] ri_readAddress;
    logic [1:0]            ri_readChannel;
    logic [7:0]            ri_readData;
    logic [ADDR_WIDTH-1:0] ri_writeAddress;
    logic [1:0]            ri_writeChannel;
    logic                  ri_writeEnable;
    logic [7:0]            ri_writeData;

    // Requester / RAM side
    modport master (
        output flush_req, flush_chMask, inv_req, inv_address, inv_channel, inv_byteMask,
        output ri_readData,
        input  flush_ack, inv_ack, ready, busy, sel,
        input  ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
        input  ri_writeEnable, ri_writeData
    );

    // Controller side
    modport slave (
        input  flush_req, flush_chMask, inv_req, inv_address, inv_channel, inv_byteMask,
        input  ri_readData,
        output flush_ack, inv_ack, ready, busy, sel,
        output ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
        output ri_writeEnable, ri_writeData
    );
endinterface

// File: rtl/cache_dre_ctrl.sv
// DRE RAM maintenance controller: post-reset clear sweep, per-channel flush, nibble invalidate.
// Latency: flush = one write per cycle for each masked channel; invalidate = 2 cycles (read, write).
// Backpressure: requests are level-held; only accepted in IDLE, flush wins over invalidate.
module cache_dre_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_dre_ctrl_if.slave    bus
);
    localparam int IW = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        FLUSH,
        INV_RD,
        INV_WR
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      ch, ch_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            ready_q, ready_nxt;

    logic            we;
    logic [1:0]      wch;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [7:0]      wdat;
    logic            fack;
    logic            iack;

    logic            last_idx;
    logic [2:0]      first_ch;  // {found, channel} lowest set channel in the mask
    logic [2:0]      next_ch;   // {found, channel} next set channel above the current one

    // Lowest channel >= from whose mask bit is set; bit 2 flags that one exists.
    function automatic logic [2:0] find_set(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign last_idx = (idx == {IW{1'b1}});
    assign first_ch = find_set(bus.flush_chMask, 3'd0);
    assign next_ch  = find_set(bus.flush_chMask, {1'b0, ch} + 3'd1);

    // State, sweep counters and the sticky ready flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= INIT;
            ch      <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            idx     <= idx_nxt;
            ready_q <= ready_nxt;
        end
    end

    // Next-state logic and RAM write/ack outputs
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        idx_nxt   = idx;
        ready_nxt = ready_q;
        we        = 1'b0;
        wch       = ch;
        waddr     = {idx, 1'b0};
        wdat      = 8'h00;
        fack      = 1'b0;
        iack      = 1'b0;

        case (state)
            INIT: begin
                // Clear every word of every channel, channel-major.
                we      = 1'b1;
                idx_nxt = idx + 1'b1;
                if (last_idx) begin
                    ch_nxt = ch + 2'd1;
                    if (ch == 2'd3) begin
                        state_nxt = IDLE;
                        ready_nxt = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = FLUSH;
                    ch_nxt    = first_ch[1:0];
                    idx_nxt   = '0;
                end else if (bus.inv_req) begin
                    state_nxt = INV_RD;
                end
            end
            FLUSH: begin
                if (!first_ch[2]) begin
                    // Empty mask: acknowledge immediately with no writes.
                    fack      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    // Mask is stable, so ch always points at a selected channel;
                    // jump straight to the next selected one at the end of a channel.
                    we      = 1'b1;
                    idx_nxt = idx + 1'b1;
                    if (last_idx) begin
                        if (next_ch[2]) begin
                            ch_nxt = next_ch[1:0];
                        end else begin
                            fack      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            INV_RD: begin
                state_nxt = INV_WR;
            end
            INV_WR: begin
                // Clear the masked bits of the addressed nibble, keep the other nibble.
                we    = 1'b1;
                wch   = bus.inv_channel;
                waddr = bus.inv_address;
                if (bus.inv_address[0]) begin
                    wdat = {bus.ri_readData[7:4] & ~bus.inv_byteMask, bus.ri_readData[3:0]};
                end else begin
                    wdat = {bus.ri_readData[7:4], bus.ri_readData[3:0] & ~bus.inv_byteMask};
                end
                iack      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Reset forces the write strobe and acks low even though INIT is already loaded.
    assign bus.ri_writeEnable  = we & rst_n;
    assign bus.ri_writeChannel = wch;
    assign bus.ri_writeAddress = waddr;
    assign bus.ri_writeData    = wdat;
    assign bus.flush_ack       = fack & rst_n;
    assign bus.inv_ack         = iack & rst_n;

    // The read port only matters in INV_RD; driving it continuously keeps the mux trivial.
    assign bus.ri_readAddress  = bus.inv_address;
    assign bus.ri_readChannel  = bus.inv_channel;

    assign bus.ready = ready_q & rst_n;
    assign bus.busy  = ~rst_n | (state != IDLE);
    assign bus.sel   = bus.busy;

endmodule

// File: tb/tb_cache_dre_ctrl.sv
// Scoreboard bench for cache_dre_ctrl: stimulus queues expected RAM writes/acks with their cycle,
// a negedge monitor pops and compares whenever the DUT writes or acks.
module tb_cache_dre_ctrl;
    localparam int AW = 8;
    localparam int NW = 1 << (AW - 1);
    localparam int K_WR = 0, K_FACK = 1, K_IACK = 2;

    typedef struct {
        int kind;
        int ch;
        int addr;
        int dat;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  q[$];
    logic [7:0] mem [4][NW];

    cache_dre_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    cache_dre_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle registered read, write on the rising edge.
    always @(posedge clk) begin
        bus.ri_readData <= mem[bus.ri_readChannel][bus.ri_readAddress[AW-1:1]];
        if (bus.ri_writeEnable)
            mem[bus.ri_writeChannel][bus.ri_writeAddress[AW-1:1]] = bus.ri_writeData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int a, input int d, input int t);
        ev_t e;
        e.kind = k; e.ch = c; e.addr = a; e.dat = d; e.cyc = t;
        q.push_back(e);
    endtask

    task automatic observe(input int k, input int c, input int a, input int d);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got unexpected kind=%0d ch=%0d addr=%h dat=%h at cycle %0d",
                     k, c, a, d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.ch != c || e.addr != a || e.dat != d || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d ch=%0d addr=%h dat=%h cyc=%0d, want kind=%0d ch=%0d addr=%h dat=%h cyc=%0d",
                         k, c, a, d, cyc, e.kind, e.ch, e.addr, e.dat, e.cyc);
            end
        end
    endtask

    // Monitor: every write and every ack must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.ri_writeEnable)
            observe(K_WR, int'(bus.ri_writeChannel), int'(bus.ri_writeAddress), int'(bus.ri_writeData));
        if (bus.flush_ack) observe(K_FACK, 0, 0, 0);
        if (bus.inv_ack)   observe(K_IACK, 0, 0, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the clear sweep over masked channels starting at cycle t0; last = cycle of final write.
    task automatic exp_sweep(input logic [3:0] mask, input int t0, output int last);
        int t;
        t = t0;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                for (int i = 0; i < NW; i++) begin
                    push(K_WR, c, 2 * i, 0, t);
                    t++;
                end
            end
        end
        last = t - 1;
    endtask

    task automatic do_reset(input int n);
        int s, l;
        q.delete();
        rst_n = 1'b0;
        bus.flush_req = 1'b0;
        bus.inv_req = 1'b0;
        repeat (n) step();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_sel", 32'(bus.sel), 32'd1);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_we", 32'(bus.ri_writeEnable), 32'd0);
        check("rst_acks", 32'({bus.flush_ack, bus.inv_ack}), 32'd0);
        rst_n = 1'b1;
        s = cyc;
        exp_sweep(4'hF, s, l);
        repeat (511) step();
        check("init_ready_low", 32'(bus.ready), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd1);
        step();
        check("init_ready", 32'(bus.ready), 32'd1);
        check("init_idle_busy", 32'(bus.busy), 32'd0);
        check("init_idle_sel", 32'(bus.sel), 32'd0);
    endtask

    initial begin
        int a, l;
        bus.flush_req = 1'b0;
        bus.flush_chMask = 4'h0;
        bus.inv_req = 1'b0;
        bus.inv_address = '0;
        bus.inv_channel = 2'd0;
        bus.inv_byteMask = 4'h0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < NW; i++) mem[c][i] = 8'h3C;

        // Power-up clear
        do_reset(3);
        check("init_mem_ch3_last", 32'(mem[3][NW-1]), 32'h00);

        // Flush channels 1 and 3
        mem[0][5] = 8'hA5; mem[2][100] = 8'h5A; mem[1][7] = 8'hEE; mem[3][127] = 8'h77;
        step();
        a = cyc;
        bus.flush_chMask = 4'b1010;
        bus.flush_req = 1'b1;
        exp_sweep(4'b1010, a + 1, l);
        push(K_FACK, 0, 0, 0, a + 256);
        repeat (256) step();
        bus.flush_req = 1'b0;
        step();
        check("flush_idle", 32'(bus.busy), 32'd0);
        check("flush_ch0_kept", 32'(mem[0][5]), 32'hA5);
        check("flush_ch2_kept", 32'(mem[2][100]), 32'h5A);
        check("flush_ch1_clr", 32'(mem[1][7]), 32'h00);
        check("flush_ch3_clr", 32'(mem[3][127]), 32'h00);

        // Invalidate odd address: high nibble
        mem[2][8'h12] = 8'hFF;
        a = cyc;
        bus.inv_address = 8'h25; bus.inv_channel = 2'd2; bus.inv_byteMask = 4'b0101;
        bus.inv_req = 1'b1;
        push(K_WR, 2, 8'h25, 8'hAF, a + 2);
        push(K_IACK, 0, 0, 0, a + 2);
        repeat (2) step();
        bus.inv_req = 1'b0;
        step();
        check("inv_odd_mem", 32'(mem[2][8'h12]), 32'hAF);

        // Invalidate even address: low nibble
        mem[1][8'h30] = 8'h5C;
        a = cyc;
        bus.inv_address = 8'h60; bus.inv_channel = 2'd1; bus.inv_byteMask = 4'b1100;
        bus.inv_req = 1'b1;
        push(K_WR, 1, 8'h60, 8'h50, a + 2);
        push(K_IACK, 0, 0, 0, a + 2);
        repeat (2) step();
        bus.inv_req = 1'b0;
        step();
        check("inv_even_mem", 32'(mem[1][8'h30]), 32'h50);

        // Simultaneous flush and invalidate: flush first
        mem[0][1] = 8'h3C;
        a = cyc;
        bus.flush_chMask = 4'b0100;
        bus.flush_req = 1'b1;
        bus.inv_address = 8'h03; bus.inv_channel = 2'd0; bus.inv_byteMask = 4'b1111;
        bus.inv_req = 1'b1;
        exp_sweep(4'b0100, a + 1, l);
        push(K_FACK, 0, 0, 0, a + 128);
        push(K_WR, 0, 8'h03, 8'h0C, a + 131);
        push(K_IACK, 0, 0, 0, a + 131);
        repeat (128) step();
        bus.flush_req = 1'b0;
        repeat (3) step();
        bus.inv_req = 1'b0;
        step();
        check("both_inv_mem", 32'(mem[0][1]), 32'h0C);

        // Empty flush mask: ack on the first FLUSH cycle, no writes
        a = cyc;
        bus.flush_chMask = 4'h0;
        bus.flush_req = 1'b1;
        push(K_FACK, 0, 0, 0, a + 1);
        step();
        bus.flush_req = 1'b0;
        repeat (2) step();
        check("zero_mask_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a full flush: no ack, full clear follows
        a = cyc;
        bus.flush_chMask = 4'hF;
        bus.flush_req = 1'b1;
        exp_sweep(4'hF, a + 1, l);
        push(K_FACK, 0, 0, 0, a + 512);
        repeat (50) step();
        do_reset(2);

        repeat (3) step();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
